div_result_bcd: RTL and testbench

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

---
 rtl/div_pkg.sv | 22 ++
 rtl/bcd_add3.sv | 14 +
 rtl/div_result_bcd.sv | 113 +++++++++++
 tb/tb_div_result_bcd.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider-result BCD conversion slice.
// Latency: none (package only).
// Backpressure: none (package only).
package div_pkg;

  // Conversion controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default quotient width; the remainder is one bit wider
  localparam int DEF_N = 4;

  // Default BCD digits per output field; 10^DIGITS must exceed 2^(N+1)-1
  localparam int DEF_DIGITS = 2;

  // Double-dabble correction threshold: digits at or above this get +3
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3
  import div_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A digit >= 5 would overflow past 9 after the next left shift
  assign digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/div_result_bcd.sv
// Converts an unsigned divider quotient/remainder pair to packed BCD via double-dabble.
// Latency: out_valid first high N+1 cycles after the accept edge (5 for N=4).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no bypass.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        quotient,
  input  logic [N:0]          remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      q_op_q, q_op_d;
  logic [N:0]      r_op_q, r_op_d;
  logic [BW-1:0]   q_acc_q, q_acc_d;
  logic [BW-1:0]   r_acc_q, r_acc_d;
  logic [BW-1:0]   q_adj, r_adj;

  // Per-digit add-3 correction on both accumulators
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_q_add3 (
      .digit_i (q_acc_q[4*g +: 4]),
      .digit_o (q_adj[4*g +: 4])
    );
    bcd_add3 u_r_add3 (
      .digit_i (r_acc_q[4*g +: 4]),
      .digit_o (r_adj[4*g +: 4])
    );
  end

  // The top accumulator bit is shifted out every step; with a legal DIGITS it is always 0
  logic unused_top_bits;
  assign unused_top_bits = q_adj[BW-1] ^ r_adj[BW-1];

  // Next-state and datapath: accept, shift-and-correct, hold for consumer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_op_d  = q_op_q;
    r_op_d  = r_op_q;
    q_acc_d = q_acc_q;
    r_acc_d = r_acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_op_d  = {1'b0, quotient};
          r_op_d  = remainder;
          q_acc_d = '0;
          r_acc_d = '0;
          cnt_d   = CW'(N + 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        q_acc_d = {q_adj[BW-2:0], q_op_q[N]};
        r_acc_d = {r_adj[BW-2:0], r_op_q[N]};
        q_op_d  = {q_op_q[N-1:0], 1'b0};
        r_op_d  = {r_op_q[N-1:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state lives here; synchronous reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_op_q  <= '0;
      r_op_q  <= '0;
      q_acc_q <= '0;
      r_acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_op_q  <= q_op_d;
      r_op_q  <= r_op_d;
      q_acc_q <= q_acc_d;
      r_acc_q <= r_acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q_bcd     = q_acc_q;
  assign r_bcd     = r_acc_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd with a cycle-level behavioural model.
// Latency: checks the N+1 cycle accept-to-result delay.
// Backpressure: exercises out_ready stalls, ignored in_valid and back-to-back accepts.
module tb_div_result_bcd;

  localparam int N      = 4;
  localparam int DIGITS = 2;
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  quotient;
  logic [N:0]    remainder;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] q_bcd;
  logic [BW-1:0] r_bcd;

  int total = 0;
  int bad   = 0;

  div_result_bcd #(.N(N), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain arithmetic
  function automatic logic [BW-1:0] to_bcd(input int v);
    int t;
    logic [BW-1:0] res;
    t   = v;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  // Behavioural model: idle / busy for N+1 edges / holding a result
  int            m_phase = 0;
  int            m_left  = 0;
  bit            m_init  = 1'b0;
  bit            m_zero  = 1'b0;
  logic [BW-1:0] m_exp_q = '0;
  logic [BW-1:0] m_exp_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_left  = 0;
      m_zero  = 1'b1;
    end else if (m_init) begin
      case (m_phase)
        0: if (in_valid) begin
          m_exp_q = to_bcd(int'(quotient));
          m_exp_r = to_bcd(int'(remainder));
          m_left  = N + 1;
          m_zero  = 1'b0;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Compare process: DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("cmp_q_bcd", 32'(q_bcd), 32'(m_exp_q));
        chk("cmp_r_bcd", 32'(r_bcd), 32'(m_exp_r));
      end
      if (m_zero) begin
        chk("cmp_zero_q", 32'(q_bcd), 32'd0);
        chk("cmp_zero_r", 32'(r_bcd), 32'd0);
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic convert(input int qv, input int rv, input logic [BW-1:0] eq, input logic [BW-1:0] er);
    int cyc;
    in_valid  = 1'b1;
    quotient  = N'(qv);
    remainder = (N+1)'(rv);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accepted", 32'(in_ready), 32'd0);
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'(N + 1));
    chk("q_lit", 32'(q_bcd), 32'(eq));
    chk("r_lit", 32'(r_bcd), 32'(er));
    chk("model_q_lit", 32'(m_exp_q), 32'(eq));
    chk("model_r_lit", 32'(m_exp_r), 32'(er));
    @(posedge clk);
    #1;
    chk("back_idle_rdy", 32'(in_ready), 32'd1);
    chk("back_idle_vld", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    quotient  = '0;
    remainder = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q_bcd), 32'd0);
    chk("rst_r", 32'(r_bcd), 32'd0);

    // Basic conversions including maximum and zero operands
    convert(13, 27, 8'h13, 8'h27);
    convert(15, 31, 8'h15, 8'h31);
    convert(0, 0, 8'h00, 8'h00);

    // Stall in DONE with a stray in_valid pulse
    in_valid  = 1'b1;
    quotient  = 4'd5;
    remainder = 5'd22;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(cyc);
    chk("hold_latency", 32'(cyc), 32'(N + 1));
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        in_valid  = 1'b1;
        quotient  = 4'd3;
        remainder = 5'd1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(q_bcd), 32'h05);
      chk("hold_r", 32'(r_bcd), 32'h22);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_rdy", 32'(in_ready), 32'd1);
    chk("release_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("stray_ignored", 32'(in_ready), 32'd1);

    // Reset during the third SHIFT cycle
    in_valid  = 1'b1;
    quotient  = 4'd12;
    remainder = 5'd30;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_q", 32'(q_bcd), 32'd0);
    chk("abort_r", 32'(r_bcd), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_vld", 32'(out_valid), 32'd0);
    end
    convert(9, 4, 8'h09, 8'h04);

    // Back-to-back with in_valid held high
    in_valid  = 1'b1;
    quotient  = 4'd7;
    remainder = 5'd3;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    quotient  = 4'd10;
    remainder = 5'd19;
    wait_done(cyc);
    chk("b2b_lat1", 32'(cyc), 32'(N + 1));
    chk("b2b_q1", 32'(q_bcd), 32'h07);
    chk("b2b_r1", 32'(r_bcd), 32'h03);
    @(posedge clk);
    #1;
    chk("b2b_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_accept2", 32'(in_ready), 32'd0);
    wait_done(cyc);
    chk("b2b_lat2", 32'(cyc), 32'(N + 1));
    chk("b2b_q2", 32'(q_bcd), 32'h10);
    chk("b2b_r2", 32'(r_bcd), 32'h19);
    @(posedge clk);
    #1;
    chk("b2b_end_rdy", 32'(in_ready), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
